// File: rtl/numeros_pkg.sv
// Shared definitions for the signed/unsigned sample accumulator.
//   estado_t         : accumulator FSM states (ACUMULA collects samples, ENTREGA holds a result).
//   MODO_*           : sample interpretation selected by modo_signed.
//   largura_contagem : width needed to count 0..n accepted samples.
package numeros_pkg;

  typedef enum logic [0:0] {
    ACUMULA = 1'b0,
    ENTREGA = 1'b1
  } estado_t;

  localparam logic MODO_UNSIGNED = 1'b0;
  localparam logic MODO_SIGNED   = 1'b1;

  // Bits needed to hold the values 0..n. Never returns less than 1.
  function automatic int unsigned largura_contagem(input int unsigned n);
    if (n < 1) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/somador_ext_ovf.sv
// Combinational extend-and-add stage of the accumulator.
//   acc      : current accumulator value (LARGURA_ACC bits).
//   amostra  : incoming sample (LARGURA_ENTRADA bits).
//   modo     : MODO_SIGNED sign-extends the sample, MODO_UNSIGNED zero-extends it.
//   soma     : acc + extended sample, wrapped modulo 2^LARGURA_ACC.
//   overflow : this single addition left the LARGURA_ACC range for the chosen mode.
module somador_ext_ovf
  import numeros_pkg::*;
#(
  parameter int unsigned LARGURA_ENTRADA = 8,
  parameter int unsigned LARGURA_ACC     = 10
) (
  input  logic [LARGURA_ACC-1:0]     acc,
  input  logic [LARGURA_ENTRADA-1:0] amostra,
  input  logic                       modo,
  output logic [LARGURA_ACC-1:0]     soma,
  output logic                       overflow
);

  localparam int unsigned Extra = LARGURA_ACC - LARGURA_ENTRADA;

  logic                   bit_ext;
  logic [LARGURA_ACC-1:0] ext;
  logic [LARGURA_ACC:0]   total;

  always_comb begin
    bit_ext = (modo == MODO_SIGNED) && amostra[LARGURA_ENTRADA-1];
    ext     = {{Extra{bit_ext}}, amostra};
    // One extra bit on both operands so total[LARGURA_ACC] is the unsigned carry out.
    total   = {1'b0, acc} + {1'b0, ext};
    soma    = total[LARGURA_ACC-1:0];
    if (modo == MODO_SIGNED) begin
      // Equal-sign operands giving a result of the other sign.
      overflow = (acc[LARGURA_ACC-1] == ext[LARGURA_ACC-1]) &&
                 (soma[LARGURA_ACC-1] != acc[LARGURA_ACC-1]);
    end else begin
      overflow = total[LARGURA_ACC];
    end
  end

endmodule

// File: rtl/acumulador_com_sinal.sv
// Block accumulator for the adder-selector result stream.
// Sums N_AMOSTRAS samples per block, interpreting them as signed or unsigned according to the
// mode captured with the first sample of the block, then holds the result until taken.
//   clk, rst_n                    : clock, asynchronous active-low reset.
//   entrada_valida/entrada_pronta : input handshake for dado/modo_signed.
//   dado                          : sample.
//   modo_signed                   : 1 = two's-complement, 0 = unsigned (first sample only).
//   soma                          : sum of the last completed block.
//   overflow                      : sticky per-block overflow of the block sum.
//   contagem                      : samples accepted in the current block.
//   saida_valida/saida_pronta     : output handshake for soma/overflow.
module acumulador_com_sinal
  import numeros_pkg::*;
#(
  parameter int unsigned LARGURA_ENTRADA = 8,
  parameter int unsigned LARGURA_ACC     = 10,
  parameter int unsigned N_AMOSTRAS      = 4,
  localparam int unsigned LARGURA_CONT   = largura_contagem(N_AMOSTRAS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       entrada_valida,
  output logic                       entrada_pronta,
  input  logic [LARGURA_ENTRADA-1:0] dado,
  input  logic                       modo_signed,
  output logic [LARGURA_ACC-1:0]     soma,
  output logic                       overflow,
  output logic [LARGURA_CONT-1:0]    contagem,
  output logic                       saida_valida,
  input  logic                       saida_pronta
);

  localparam logic [LARGURA_CONT-1:0] UltimaContagem = LARGURA_CONT'(N_AMOSTRAS - 1);

  estado_t                 estado_q;
  logic [LARGURA_ACC-1:0]  acc_q;
  logic                    ovf_acc_q;
  logic                    modo_q;
  logic [LARGURA_ACC-1:0]  soma_q;
  logic                    overflow_q;
  logic [LARGURA_CONT-1:0] contagem_q;

  logic                    transferencia;
  logic                    ultima;
  logic                    modo_ativo;
  logic [LARGURA_ACC-1:0]  soma_nova;
  logic                    ovf_add;

  always_comb begin
    entrada_pronta = (estado_q == ACUMULA);
    saida_valida   = (estado_q == ENTREGA);
    transferencia  = entrada_valida && entrada_pronta;
    ultima         = (contagem_q == UltimaContagem);
    // The first sample of a block uses the live mode; the rest use the latched copy.
    modo_ativo     = (contagem_q == '0) ? modo_signed : modo_q;
  end

  somador_ext_ovf #(
    .LARGURA_ENTRADA(LARGURA_ENTRADA),
    .LARGURA_ACC    (LARGURA_ACC)
  ) u_somador (
    .acc     (acc_q),
    .amostra (dado),
    .modo    (modo_ativo),
    .soma    (soma_nova),
    .overflow(ovf_add)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= ACUMULA;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
      modo_q     <= MODO_UNSIGNED;
      soma_q     <= '0;
      overflow_q <= 1'b0;
      contagem_q <= '0;
    end else begin
      unique case (estado_q)
        ACUMULA: begin
          if (transferencia) begin
            if (contagem_q == '0) begin
              modo_q <= modo_signed;
            end
            acc_q      <= soma_nova;
            ovf_acc_q  <= ovf_acc_q | ovf_add;
            contagem_q <= contagem_q + LARGURA_CONT'(1);
            if (ultima) begin
              soma_q     <= soma_nova;
              overflow_q <= ovf_acc_q | ovf_add;
              estado_q   <= ENTREGA;
            end
          end
        end
        ENTREGA: begin
          if (saida_pronta) begin
            // soma_q deliberately keeps the delivered block value.
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            overflow_q <= 1'b0;
            contagem_q <= '0;
            estado_q   <= ACUMULA;
          end
        end
        default: estado_q <= ACUMULA;
      endcase
    end
  end

  always_comb begin
    soma     = soma_q;
    overflow = overflow_q;
    contagem = contagem_q;
  end

endmodule

// File: tb/tb_acumulador_com_sinal.sv
// Directed bench for acumulador_com_sinal: a 10-bit and a 9-bit accumulator share one stimulus
// stream; an integer reference model pushes expected block results into a scoreboard queue.
module tb_acumulador_com_sinal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entrada_valida = 1'b0;
  logic [7:0] dado = '0;
  logic       modo_signed = 1'b0;
  logic       saida_pronta = 1'b1;

  logic       pronta10, valida10, ovf10, pronta9, valida9, ovf9;
  logic [9:0] soma10;
  logic [8:0] soma9;
  logic [2:0] cont10, cont9;

  always #5 clk = ~clk;

  acumulador_com_sinal #(.LARGURA_ENTRADA(8), .LARGURA_ACC(10), .N_AMOSTRAS(4)) dut (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta10),
    .dado(dado), .modo_signed(modo_signed), .soma(soma10), .overflow(ovf10),
    .contagem(cont10), .saida_valida(valida10), .saida_pronta(saida_pronta)
  );

  acumulador_com_sinal #(.LARGURA_ENTRADA(8), .LARGURA_ACC(9), .N_AMOSTRAS(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .entrada_pronta(pronta9),
    .dado(dado), .modo_signed(modo_signed), .soma(soma9), .overflow(ovf9),
    .contagem(cont9), .saida_valida(valida9), .saida_pronta(saida_pronta)
  );

  typedef struct {
    logic [9:0] s10;
    logic       o10;
    logic [8:0] s9;
    logic       o9;
  } esperado_t;

  esperado_t sb[$];
  esperado_t ultimo;

  int   n_chk = 0;
  int   n_fail = 0;
  int   m_acc10 = 0, m_acc9 = 0, m_cnt = 0;
  bit   m_o10 = 0, m_o9 = 0;
  logic m_modo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on plain integers for a w-bit accumulator.
  function automatic void passo(input int w, input int acc, input bit ovf_in, input logic [7:0] d,
                                input logic modo, output int nacc, output bit novf);
    int v, r, a;
    bit o;
    v = int'(d);
    if (modo) begin
      if (d[7]) v = v - 256;
      a = (acc >= (1 << (w - 1))) ? acc - (1 << w) : acc;
      r = a + v;
      o = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
    end else begin
      r = acc + v;
      o = (r >= (1 << w));
    end
    nacc = r & ((1 << w) - 1);
    novf = ovf_in | o;
  endfunction

  task automatic modelo_reset();
    m_acc10 = 0; m_acc9 = 0; m_cnt = 0; m_o10 = 0; m_o9 = 0; m_modo = 1'b0;
  endtask

  // Drive one sample and wait (bounded) for it to be accepted; inputs change at posedge+1.
  task automatic send(input logic [7:0] d, input logic m);
    int n;
    esperado_t e;
    entrada_valida = 1'b1;
    dado = d;
    modo_signed = m;
    n = 0;
    while (!pronta10 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pronta10) begin
      chk("pronta_timeout", {31'd0, pronta10}, 32'd1);
      entrada_valida = 1'b0;
      return;
    end
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    if (m_cnt == 0) m_modo = m;
    passo(10, m_acc10, m_o10, d, m_modo, m_acc10, m_o10);
    passo(9, m_acc9, m_o9, d, m_modo, m_acc9, m_o9);
    m_cnt++;
    if (m_cnt == 4) begin
      e.s10 = 10'(m_acc10); e.o10 = m_o10;
      e.s9 = 9'(m_acc9); e.o9 = m_o9;
      sb.push_back(e);
      modelo_reset();
    end
  endtask

  // Called at the phase right after the last accepted sample: result must already be valid.
  task automatic check_out(input string tag);
    chk({tag, "_valida"}, {31'd0, valida10}, 32'd1);
    chk({tag, "_valida9"}, {31'd0, valida9}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_vazio"}, 32'(sb.size()), 32'd1);
      return;
    end
    ultimo = sb.pop_front();
    chk({tag, "_soma10"}, {22'd0, soma10}, {22'd0, ultimo.s10});
    chk({tag, "_ovf10"}, {31'd0, ovf10}, {31'd0, ultimo.o10});
    chk({tag, "_soma9"}, {23'd0, soma9}, {23'd0, ultimo.s9});
    chk({tag, "_ovf9"}, {31'd0, ovf9}, {31'd0, ultimo.o9});
    chk({tag, "_contagem"}, {29'd0, cont10}, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_soma", {22'd0, soma10}, 32'd0);
    chk("rst_valida", {31'd0, valida10}, 32'd0);
    chk("rst_pronta", {31'd0, pronta10}, 32'd1);
    chk("rst_contagem", {29'd0, cont10}, 32'd0);
    chk("rst_ovf", {31'd0, ovf10}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unsigned 4x FF: 1020; 9-bit copy wraps to 0x1FC with overflow
    for (int i = 0; i < 3; i++) send(8'hFF, 1'b0);
    chk("t1_valida_cedo", {31'd0, valida10}, 32'd0);
    chk("t1_contagem3", {29'd0, cont10}, 32'd3);
    send(8'hFF, 1'b0);
    check_out("t1");

    // Signed 4x 0x80 then 4x 0x7F
    for (int i = 0; i < 4; i++) send(8'h80, 1'b1);
    check_out("t2a");
    for (int i = 0; i < 4; i++) send(8'h7F, 1'b1);
    check_out("t2b");

    // Sticky overflow cleared for the next block
    for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
    check_out("t3");
    chk("t3_ovf9_limpo", {31'd0, ovf9}, 32'd0);

    // Mode latched from the first sample only
    send(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h01, 1'b0);
    check_out("t4");
    chk("t4_soma_literal", {22'd0, soma10}, 32'h002);

    // Backpressure: result held, upstream stalled
    for (int i = 0; i < 3; i++) send(8'h10, 1'b0);
    saida_pronta = 1'b0;
    send(8'h10, 1'b0);
    check_out("t5");
    for (int i = 0; i < 5; i++) begin
      entrada_valida = 1'b1;
      dado = 8'(8'h20 + i * 3);
      modo_signed = 1'b0;
      @(posedge clk); #1;
      chk("t5_pronta_baixa", {31'd0, pronta10}, 32'd0);
      chk("t5_valida_mantida", {31'd0, valida10}, 32'd1);
      chk("t5_soma_estavel", {22'd0, soma10}, {22'd0, ultimo.s10});
      chk("t5_contagem_mantida", {29'd0, cont10}, 32'd4);
    end
    saida_pronta = 1'b1;
    @(posedge clk); #1;
    chk("t5_valida_pos", {31'd0, valida10}, 32'd0);
    chk("t5_pronta_pos", {31'd0, pronta10}, 32'd1);
    chk("t5_contagem_zero", {29'd0, cont10}, 32'd0);
    chk("t5_ovf_zero", {31'd0, ovf10}, 32'd0);
    chk("t5_soma_mantida", {22'd0, soma10}, {22'd0, ultimo.s10});
    // The sample held during the stall is the first of the next block
    send(dado, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h05, 1'b0);
    check_out("t5b");

    // Asynchronous reset mid-block
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    chk("t6_contagem2", {29'd0, cont10}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_soma", {22'd0, soma10}, 32'd0);
    chk("t6_rst_soma9", {23'd0, soma9}, 32'd0);
    chk("t6_rst_contagem", {29'd0, cont10}, 32'd0);
    chk("t6_rst_valida", {31'd0, valida10}, 32'd0);
    chk("t6_rst_ovf", {31'd0, ovf10}, 32'd0);
    modelo_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
    check_out("t6");
    chk("t6_soma_literal", {22'd0, soma10}, 32'h004);
    chk("sb_final_vazio", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
